ds_pipe_buf: RTL and testbench
==============================

DS_PIPE_BUF -- requirements
Module: ds_pipe_buf

Interface
REQ-001 Parameter DATA_W, default 64, SHALL set the width of the fetch-to-decode bundle {inst, pc}.
REQ-002 Parameter DEPTH, default 2, SHALL set the number of buffered entries; legal values are powers of two >= 2.
REQ-003 Parameter INST_LSB, default 32, SHALL give the bit position of the 32-bit instruction field inside the bundle.
REQ-004 Parameter NOP_INST, default 32'h00000033 (ADD x0,x0,x0), SHALL be the instruction substituted on flush.
REQ-005 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 fs_to_ds_valid  input  1  fetch offers a bundle this cycle.
REQ-008 if_id_bus_in  input  DATA_W  offered bundle.
REQ-009 ds_allowin  output  1  buffer accepts a bundle this cycle.
REQ-010 flush  input  1  branch/jump redirect; kills all buffered bundles.
REQ-011 stall  input  1  decode hazard; head bundle is not ready to go.
REQ-012 es_allowin  input  1  execute stage accepts a bundle this cycle.
REQ-013 ds_to_es_valid  output  1  head bundle is presented to execute.
REQ-014 id_bus_out  output  DATA_W  head bundle, inst field possibly replaced per REQ-022.
REQ-015 count  output  $clog2(DEPTH+1)  number of occupied entries.

Function
REQ-016 Storage SHALL be a circular buffer of DEPTH entries with read pointer, write pointer and occupancy counter.
REQ-017 pop SHALL be ds_to_es_valid && es_allowin; ds_to_es_valid SHALL be (count != 0) && !stall && !flush.
REQ-018 ds_allowin SHALL be (count < DEPTH) || pop, combinationally, so a full buffer accepts a push in the same cycle it pops.
REQ-019 push SHALL be fs_to_ds_valid && ds_allowin && !flush; the bundle SHALL be written at the write pointer with 1-cycle latency to visibility.
REQ-020 Push into an empty buffer SHALL appear on id_bus_out with ds_to_es_valid high the next cycle (1-cycle latency, no combinational bypass).
REQ-021 Simultaneous push and pop SHALL leave count unchanged and advance both pointers; pointers SHALL wrap from DEPTH-1 to 0.
REQ-022 While flush is high, id_bus_out SHALL present the head entry with bits [INST_LSB+31:INST_LSB] replaced by NOP_INST; pc bits pass unchanged.
REQ-023 On a clock edge with flush high, count and both pointers SHALL return to 0, any same-cycle push SHALL be dropped, and no pop SHALL occur.
REQ-024 While stall is high (flush low), head entry, pointers and id_bus_out SHALL hold; pushes SHALL continue while count < DEPTH.
REQ-025 count SHALL never exceed DEPTH nor go below 0; pop on empty and push on full-without-pop SHALL be impossible by construction.
REQ-026 Entries SHALL be delivered strictly in push order with no loss or duplication absent flush.

Reset
REQ-027 On rst_n low, asynchronously: count = 0, pointers = 0, all storage = 0, hence ds_to_es_valid = 0, ds_allowin = 1, id_bus_out = 0.
REQ-028 Reset asserted mid-operation SHALL discard all entries; first push after release SHALL behave as on an empty buffer.

Verification
REQ-029 Push pc=0x100, inst=0x00500093, es_allowin=1 -> next cycle ds_to_es_valid=1, id_bus_out={0x00500093,0x100}, count=1; popped the following edge.
REQ-030 es_allowin=0, push 0x100,0x104 -> count=2, ds_allowin=0; third offer 0x108 held off; raise es_allowin -> 0x100 popped and 0x108 accepted same cycle, order 0x100,0x104,0x108.
REQ-031 count=2, flush=1 one cycle with push offered -> that cycle id_bus_out inst=0x00000033, ds_to_es_valid=0; next cycle count=0, pushed bundle absent.
REQ-032 Head 0x200, stall=1 for 3 cycles with es_allowin=1 -> id_bus_out stable at 0x200, ds_to_es_valid=0, no pop; stall=0 -> 0x200 popped.
REQ-033 DEPTH=4: 10 pushes/pops with random es_allowin -> pointers wrap, output order equals input order, count within 0..4.
REQ-034 rst_n pulsed low between edges with count=2 -> immediately count=0, ds_to_es_valid=0, ds_allowin=1.

Source files
------------

// File: rtl/ds_pipe_buf.sv
`default_nettype none
// ============================================================================
// Module   : ds_pipe_buf
// Brief    : Fetch-to-decode elastic buffer. A circular queue of DEPTH
//            {inst, pc} bundles with flush (NOP substitution, drop all),
//            stall (hold head) and same-cycle push-on-pop when full.
// Revision : 1.0 - initial release
// ============================================================================
module ds_pipe_buf #(
  parameter int          DATA_W   = 64,
  parameter int          DEPTH    = 2,
  parameter int          INST_LSB = 32,
  parameter logic [31:0] NOP_INST = 32'h00000033
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fs_to_ds_valid,
  input  logic [DATA_W-1:0]            if_id_bus_in,
  output logic                         ds_allowin,
  input  logic                         flush,
  input  logic                         stall,
  input  logic                         es_allowin,
  output logic                         ds_to_es_valid,
  output logic [DATA_W-1:0]            id_bus_out,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_pop;
  logic              w_push;
  logic [DATA_W-1:0] w_head;

  // Handshakes: a full buffer still accepts when its head leaves this cycle;
  // flush suppresses both presentation and acceptance.
  always_comb begin
    ds_to_es_valid = (r_count != '0) && !stall && !flush;
    w_pop          = ds_to_es_valid && es_allowin;
    ds_allowin     = (r_count < C_DEPTH) || w_pop;
    w_push         = fs_to_ds_valid && ds_allowin && !flush;
  end

  // Head presentation; during flush the instruction slot shows a NOP so
  // nothing downstream can act on a squashed instruction.
  always_comb begin
    w_head = r_mem[r_rd_ptr];
    if (flush) begin
      w_head[INST_LSB +: 32] = NOP_INST;
    end
  end

  assign id_bus_out = w_head;
  assign count      = r_count;

  // Storage write at the write pointer; pointers wrap naturally since DEPTH
  // is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= if_id_bus_in;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the queue outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CNT_ONE;
        2'b01:   r_count <= r_count - C_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ds_pipe_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_ds_pipe_buf
// Brief    : Directed self-checking bench for ds_pipe_buf (DEPTH=2 and a
//            DEPTH=4 instance for pointer wrap and ordering).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ds_pipe_buf;

  logic clk;
  logic rst_n;

  // DEPTH=2 instance
  logic        v, flush, stall, ea, alw, ov;
  logic [63:0] bus, ob;
  logic [1:0]  cnt;

  // DEPTH=4 instance
  logic        v4, flush4, stall4, ea4, alw4, ov4;
  logic [63:0] bus4, ob4;
  logic [2:0]  cnt4;

  int checks   = 0;
  int failures = 0;

  ds_pipe_buf #(.DATA_W(64), .DEPTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .fs_to_ds_valid(v), .if_id_bus_in(bus),
    .ds_allowin(alw), .flush(flush), .stall(stall), .es_allowin(ea),
    .ds_to_es_valid(ov), .id_bus_out(ob), .count(cnt)
  );

  ds_pipe_buf #(.DATA_W(64), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .fs_to_ds_valid(v4), .if_id_bus_in(bus4),
    .ds_allowin(alw4), .flush(flush4), .stall(stall4), .es_allowin(ea4),
    .ds_to_es_valid(ov4), .id_bus_out(ob4), .count(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven 2 units after it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [63:0] mk(input logic [31:0] pc);
    return {32'h00A00000 | pc, pc};
  endfunction

  logic [63:0] q[$];
  int          pushed;
  logic        exp_v, exp_pop, exp_alw;

  initial begin
    rst_n = 1'b0;
    v = 0; bus = '0; flush = 0; stall = 0; ea = 0;
    v4 = 0; bus4 = '0; flush4 = 0; stall4 = 0; ea4 = 0;
    #3;
    check("rst_count", 64'(cnt), 64'd0);
    check("rst_valid", 64'(ov), 64'd0);
    check("rst_allowin", 64'(alw), 64'd1);
    check("rst_bus", ob, 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Single push, 1-cycle visibility, popped next edge
    v = 1; bus = {32'h00500093, 32'h00000100}; ea = 1;
    tick();
    v = 0; #1;
    check("p1_valid", 64'(ov), 64'd1);
    check("p1_bus", ob, {32'h00500093, 32'h00000100});
    check("p1_count", 64'(cnt), 64'd1);
    tick(); #1;
    check("p1_popped_count", 64'(cnt), 64'd0);
    check("p1_popped_valid", 64'(ov), 64'd0);

    // Fill while blocked, then push-on-pop when full
    ea = 0; v = 1; bus = mk(32'h100);
    tick();
    bus = mk(32'h104); #1;
    check("fill_count1", 64'(cnt), 64'd1);
    tick();
    bus = mk(32'h108); #1;
    check("fill_count2", 64'(cnt), 64'd2);
    check("full_allowin", 64'(alw), 64'd0);
    check("full_valid", 64'(ov), 64'd1);
    tick(); #1;
    check("held_count", 64'(cnt), 64'd2);
    check("held_head", ob, mk(32'h100));
    ea = 1; #1;
    check("pop_allowin", 64'(alw), 64'd1);
    tick();
    v = 0; #1;
    check("ord_head104", ob, mk(32'h104));
    check("ord_count", 64'(cnt), 64'd2);
    tick(); #1;
    check("ord_head108", ob, mk(32'h108));
    check("ord_count1", 64'(cnt), 64'd1);
    tick(); #1;
    check("ord_empty", 64'(cnt), 64'd0);

    // Flush with a full buffer and a push offered
    ea = 0; v = 1; bus = mk(32'h300);
    tick();
    bus = mk(32'h304);
    tick();
    bus = mk(32'h308); flush = 1; ea = 1; #1;
    check("fl_bus_nop", ob, {32'h00000033, 32'h00000300});
    check("fl_valid", 64'(ov), 64'd0);
    check("fl_count_before", 64'(cnt), 64'd2);
    tick();
    flush = 0; v = 0; ea = 0; #1;
    check("fl_count_after", 64'(cnt), 64'd0);
    check("fl_valid_after", 64'(ov), 64'd0);
    v = 1; bus = mk(32'h400);
    tick();
    v = 0; #1;
    check("fl_next_head", ob, mk(32'h400));
    check("fl_next_count", 64'(cnt), 64'd1);
    ea = 1;
    tick(); #1;
    check("fl_next_drained", 64'(cnt), 64'd0);

    // Stall holds the head while pushes continue
    ea = 1; stall = 1; v = 1; bus = mk(32'h200);
    tick();
    bus = mk(32'h204); #1;
    check("st1_valid", 64'(ov), 64'd0);
    check("st1_head", ob, mk(32'h200));
    check("st1_allowin", 64'(alw), 64'd1);
    check("st1_count", 64'(cnt), 64'd1);
    tick();
    v = 0; #1;
    check("st2_head", ob, mk(32'h200));
    check("st2_valid", 64'(ov), 64'd0);
    check("st2_allowin", 64'(alw), 64'd0);
    check("st2_count", 64'(cnt), 64'd2);
    tick(); #1;
    check("st3_head", ob, mk(32'h200));
    check("st3_count", 64'(cnt), 64'd2);
    stall = 0; #1;
    check("st_rel_valid", 64'(ov), 64'd1);
    check("st_rel_head", ob, mk(32'h200));
    tick(); #1;
    check("st_pop_head", ob, mk(32'h204));
    check("st_pop_count", 64'(cnt), 64'd1);
    tick(); #1;
    check("st_empty", 64'(cnt), 64'd0);

    // Asynchronous reset mid-operation
    ea = 0; v = 1; bus = mk(32'h600);
    tick();
    bus = mk(32'h604);
    tick();
    v = 0; #1;
    check("ar_count_pre", 64'(cnt), 64'd2);
    rst_n = 1'b0; #1;
    check("ar_count", 64'(cnt), 64'd0);
    check("ar_valid", 64'(ov), 64'd0);
    check("ar_allowin", 64'(alw), 64'd1);
    check("ar_bus", ob, 64'd0);
    rst_n = 1'b1;
    v = 1; bus = mk(32'h500);
    tick();
    v = 0; #1;
    check("ar_first_valid", 64'(ov), 64'd1);
    check("ar_first_head", ob, mk(32'h500));
    check("ar_first_count", 64'(cnt), 64'd1);

    // DEPTH=4: wrap and ordering against a queue model
    pushed = 0;
    for (int c = 0; c < 200 && !(pushed == 10 && q.size() == 0); c++) begin
      v4   = (pushed < 10);
      bus4 = mk(32'(32'h1000 + 4 * pushed));
      ea4  = (c < 6) ? 1'b0 : 1'($urandom_range(0, 1));
      #1;
      exp_v   = (q.size() != 0);
      exp_pop = exp_v && ea4;
      exp_alw = (q.size() < 4) || exp_pop;
      check("d4_count", 64'(cnt4), 64'(q.size()));
      check("d4_valid", 64'(ov4), 64'(exp_v));
      check("d4_allowin", 64'(alw4), 64'(exp_alw));
      if (exp_pop) begin
        check("d4_order", ob4, q[0]);
        void'(q.pop_front());
      end
      if (v4 && exp_alw) begin
        q.push_back(bus4);
        pushed++;
      end
      tick();
    end
    v4 = 0; ea4 = 0;
    check("d4_all_pushed", 64'(pushed), 64'd10);
    check("d4_drained", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
